// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential 16-by-8 restoring divider.
package seq_div_pkg;

   // Controller states: waiting for operands, iterating, holding the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } seq_div_state_e;

   // Default operand width: divisor, quotient and remainder are DIV_W bits.
   localparam int DIV_W = 8;

   // Ceiling log2, used to size the iteration counter.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'sd1 << i) < value) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
// R is carried as W bits because it is always below the divisor between steps;
// only the shifted value needs the extra bit.
import seq_div_pkg::*;

module seq_div_step #(
   parameter int W = DIV_W
) (
   input  logic [W-1:0] r_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] r_o,
   output logic [W-1:0] q_o
);

   logic [W:0]   r_sh_s;
   logic [W-1:0] q_sh_s;
   logic         fits_s;

   // Shift, compare against the divisor and restore or keep the difference.
   always_comb begin
      r_sh_s = {r_i, q_i[W-1]};
      q_sh_s = {q_i[W-2:0], 1'b0};
      fits_s = (r_sh_s >= {1'b0, divisor_i});
      if (fits_s) begin
         r_o = W'(r_sh_s - {1'b0, divisor_i});
         q_o = {q_sh_s[W-1:1], 1'b1};
      end else begin
         r_o = r_sh_s[W-1:0];
         q_o = q_sh_s;
      end
   end

endmodule

// File: rtl/seq_div_16by8.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, valid/ready on both sides.
// Optional macro SEQ_DIV_EARLY_EXIT_EN: divide-by-zero and overflow skip the
// iteration and present their fixed results one cycle after acceptance.
// Without it every operation takes the same number of cycles and the step
// logic is frozen for the special cases.
import seq_div_pkg::*;

module seq_div_16by8 #(
   parameter int W = DIV_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   quotient,
   output logic [W-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   seq_div_state_e state_q, state_d;
   logic [W-1:0]   r_q, r_d;
   logic [W-1:0]   q_q, q_d;
   logic [W-1:0]   dsr_q, dsr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   quotient_q, quotient_d;
   logic [W-1:0]   remainder_q, remainder_d;
   logic           div_by_zero_q, div_by_zero_d;
   logic           overflow_q, overflow_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;

   logic           dbz_in_s;
   logic           ovf_in_s;
   logic [W-1:0]   step_r_s;
   logic [W-1:0]   step_q_s;

   seq_div_step #(.W(W)) u_step (
      .r_i       (r_q),
      .q_i       (q_q),
      .divisor_i (dsr_q),
      .r_o       (step_r_s),
      .q_o       (step_q_s)
   );

   // Special-case detection on the incoming operands.
   always_comb begin
      dbz_in_s = (divisor == '0);
      ovf_in_s = (divisor != '0) && (dividend[2*W-1:W] >= divisor);
   end

   // Next-state, datapath and output computation for the controller.
   always_comb begin
      state_d       = state_q;
      r_d           = r_q;
      q_d           = q_q;
      dsr_d         = dsr_q;
      cnt_d         = cnt_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      overflow_d    = overflow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               r_d           = dividend[2*W-1:W];
               q_d           = dividend[W-1:0];
               dsr_d         = divisor;
               cnt_d         = '0;
               div_by_zero_d = dbz_in_s;
               overflow_d    = ovf_in_s;
               state_d       = CALC;
`ifdef SEQ_DIV_EARLY_EXIT_EN
               if (dbz_in_s || ovf_in_s) begin
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dbz_in_s ? dividend[W-1:0] : '0;
               end else begin
                  state_d = CALC;
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            cnt_d = cnt_q + CW'(1);
            // Special cases freeze R/Q so the dividend low half survives.
            if (!(div_by_zero_q || overflow_q)) begin
               r_d = step_r_s;
               q_d = step_q_s;
            end else begin
               r_d = r_q;
               q_d = q_q;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               if (div_by_zero_q) begin
                  quotient_d  = '1;
                  remainder_d = q_q;
               end else if (overflow_q) begin
                  quotient_d  = '1;
                  remainder_d = '0;
               end else begin
                  quotient_d  = step_q_s;
                  remainder_d = step_r_s;
               end
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State, datapath and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         r_q           <= '0;
         q_q           <= '0;
         dsr_q         <= '0;
         cnt_q         <= '0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         overflow_q    <= 1'b0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         r_q           <= r_d;
         q_q           <= q_d;
         dsr_q         <= dsr_d;
         cnt_q         <= cnt_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
         overflow_q    <= overflow_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Self-checking bench for seq_div_16by8: directed corner cases plus random
// operands compared against plain integer division.
module tb_seq_div_16by8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   seq_div_16by8 #(.W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Count a comparison and report it when observed differs from expected.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division with the fixed special-case results.
   task automatic ref_div(input logic [15:0] dd, input logic [7:0] ds,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dbz, output logic ovf);
      int quo;
      dbz = 1'b0;
      ovf = 1'b0;
      if (ds == 8'd0) begin
         dbz = 1'b1;
         q   = 8'hFF;
         r   = dd[7:0];
      end else begin
         quo = int'(dd) / int'(ds);
         if (quo > 255) begin
            ovf = 1'b1;
            q   = 8'hFF;
            r   = 8'h00;
         end else begin
            q = quo[7:0];
            r = 8'(int'(dd) % int'(ds));
         end
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"},    in_ready,    32'd1);
      chk({tag, "_out_valid"},   out_valid,   32'd0);
      chk({tag, "_quotient"},    quotient,    32'd0);
      chk({tag, "_remainder"},   remainder,   32'd0);
      chk({tag, "_div_by_zero"}, div_by_zero, 32'd0);
      chk({tag, "_overflow"},    overflow,    32'd0);
   endtask

   // One full transaction: accept, wait for the result, optionally stall, pop.
   task automatic run_div(input logic [15:0] dd, input logic [7:0] ds,
                          input int hold, input bit early_rdy);
      logic [7:0] eq, er;
      logic       edbz, eovf;
      int         lat, exp_lat;
      ref_div(dd, ds, eq, er, edbz, eovf);
      exp_lat = 9;
`ifdef SEQ_DIV_EARLY_EXIT_EN
      if (edbz || eovf) exp_lat = 1;
`endif
      chk("idle_in_ready", in_ready, 32'd1);
      dividend  = dd;
      divisor   = ds;
      in_valid  = 1'b1;
      out_ready = early_rdy;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency",     lat,         exp_lat);
      chk("quotient",    quotient,    {24'd0, eq});
      chk("remainder",   remainder,   {24'd0, er});
      chk("div_by_zero", div_by_zero, {31'd0, edbz});
      chk("overflow",    overflow,    {31'd0, eovf});
      chk("busy_ready",  in_ready,    32'd0);
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("hold_valid",     out_valid, 32'd1);
         chk("hold_ready",     in_ready,  32'd0);
         chk("hold_quotient",  quotient,  {24'd0, eq});
         chk("hold_remainder", remainder, {24'd0, er});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("pop_valid", out_valid, 32'd0);
      chk("pop_ready", in_ready,  32'd1);
   endtask

   // Stimulus sequence.
   initial begin
      logic [7:0]  ds, a, r;
      logic [15:0] dd;
      bit          er;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = 16'd0;
      divisor   = 8'd0;
      #12;
      chk_reset_values("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      run_div(16'h03E8, 8'h07, 0, 1'b0);
      run_div(16'hFE01, 8'hFF, 0, 1'b0);
      run_div(16'h00FF, 8'h01, 0, 1'b0);
      run_div(16'h1234, 8'h00, 0, 1'b0);
      run_div(16'h0100, 8'h01, 0, 1'b0);
      run_div(16'h03E8, 8'h07, 5, 1'b0);
      run_div(16'h2710, 8'h64, 0, 1'b1);

      // Abort an operation at CALC step 3 with an asynchronous reset.
      dividend = 16'h1234;
      divisor  = 8'h56;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_values("midcalc_reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_div(16'h0064, 8'h0A, 0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         ds = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         if ($urandom_range(0, 1) == 0 || ds == 8'd0) begin
            dd = 16'($urandom);
         end else begin
            a  = 8'($urandom);
            r  = 8'($urandom_range(0, int'(ds) - 1));
            dd = 16'(int'(a) * int'(ds) + int'(r));
         end
         er = 1'($urandom_range(0, 1));
         run_div(dd, ds, er ? 0 : $urandom_range(0, 2), er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "time limit reached");
   end

endmodule
